// File: rtl/interrupt_pkg.sv
// rtl/interrupt_pkg.sv - shared types and constants for the interrupt sequencer
package interrupt_pkg;

    localparam int INT_ID_W = 4;
    localparam int NEST_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_ARMED,
        ST_VEC,
        ST_LOAD
    } seq_state_t;

    // Default return-stack frame for a 16-bit PC; wider PCs supply their own type
    typedef struct packed {
        logic [15:0]         pc;
        logic [INT_ID_W-1:0] id;
    } stack_entry_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of {pc, id} frames for nested interrupt returns
module return_stack
    import interrupt_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = stack_entry_t
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  entry_t            push_data,
    input  logic              pop,
    output entry_t            top,
    output logic [NEST_W-1:0] depth,
    output logic              full,
    output logic              empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t            mem [DEPTH];
    logic [NEST_W-1:0] depth_q;
    logic [NEST_W-1:0] top_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = (depth_q == NEST_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~do_push;
    assign top_idx = depth_q - NEST_W'(1);
    assign top     = empty ? '0 : mem[top_idx[IW-1:0]];
    assign depth   = depth_q;

    // Occupancy count; only this is cleared by reset, stale frames are unreachable
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else if (do_push) begin
            depth_q <= depth_q + NEST_W'(1);
        end else if (do_pop) begin
            depth_q <= depth_q - NEST_W'(1);
        end
    end

    // Frame storage written at the current free slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[depth_q[IW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - accepts interrupts at instruction boundaries and redirects the PC
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter int              DEPTH    = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] VEC_BASE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                int_enable,
    input  logic                insn_boundary,
    input  logic [PC_W-1:0]     current_pc,
    input  logic                reti,
    output logic                handle_interrupt,
    input  logic                cpu_interrupt,
    input  logic [INT_ID_W-1:0] cpu_interrupt_id,
    output logic                clear_interrupt,
    output logic [INT_ID_W-1:0] clear_interrupt_id,
    output logic                vec_rd,
    output logic [PC_W-1:0]     vec_addr,
    input  logic [PC_W-1:0]     vec_data,
    output logic                stall,
    output logic                pc_load,
    output logic [PC_W-1:0]     pc_value,
    output logic [NEST_W-1:0]   nest_depth,
    output logic                reti_err
);

    typedef struct packed {
        logic [PC_W-1:0]     pc;
        logic [INT_ID_W-1:0] id;
    } seq_entry_t;

    seq_state_t          state_q, state_d;
    logic [INT_ID_W-1:0] pend_id_q, pend_id_d;
    logic [PC_W-1:0]     save_pc_q, save_pc_d;

    logic                stk_push;
    logic                stk_pop;
    seq_entry_t          stk_top;
    seq_entry_t          stk_push_data;
    logic [NEST_W-1:0]   stk_depth;
    logic                stk_full;
    logic                stk_empty;
    logic                reti_now;
    logic                reti_window;

    assign reti_now      = reti & insn_boundary;
    assign reti_window   = (state_q == ST_IDLE) || (state_q == ST_ACK) || (state_q == ST_ARMED);
    assign stk_push_data = '{pc: save_pc_q, id: pend_id_q};
    assign nest_depth    = reset ? '0 : stk_depth;

    return_stack #(
        .DEPTH   (DEPTH),
        .entry_t (seq_entry_t)
    ) u_return_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (stk_push),
        .push_data (stk_push_data),
        .pop       (stk_pop),
        .top       (stk_top),
        .depth     (stk_depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // State, accepted id and the return PC captured at the vectoring boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_id_q <= '0;
            save_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_id_q <= pend_id_d;
            save_pc_q <= save_pc_d;
        end
    end

    // Next state and all handshake/redirect outputs; RETI servicing overlays the idle-side states
    always_comb begin
        state_d            = state_q;
        pend_id_d          = pend_id_q;
        save_pc_d          = save_pc_q;
        handle_interrupt   = 1'b0;
        clear_interrupt    = 1'b0;
        clear_interrupt_id = '0;
        vec_rd             = 1'b0;
        vec_addr           = '0;
        stall              = 1'b0;
        pc_load            = 1'b0;
        pc_value           = '0;
        reti_err           = 1'b0;
        stk_push           = 1'b0;
        stk_pop            = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    // A RETI clears this cycle, and the controller drops a handle seen together with a clear
                    handle_interrupt = int_enable & ~stk_full & ~reti_now;
                    if (handle_interrupt) begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (cpu_interrupt) begin
                        pend_id_d = cpu_interrupt_id;
                        state_d   = ST_ARMED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    // Already accepted by the controller, so int_enable no longer matters
                    if (insn_boundary && !reti) begin
                        save_pc_d = current_pc;
                        state_d   = ST_VEC;
                    end
                end
                ST_VEC: begin
                    stall    = 1'b1;
                    vec_rd   = 1'b1;
                    vec_addr = VEC_BASE + PC_W'(pend_id_q);
                    state_d  = ST_LOAD;
                end
                ST_LOAD: begin
                    stall    = 1'b1;
                    pc_load  = 1'b1;
                    pc_value = vec_data;
                    stk_push = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (reti_now && reti_window) begin
                if (!stk_empty) begin
                    pc_load            = 1'b1;
                    pc_value           = stk_top.pc;
                    clear_interrupt    = 1'b1;
                    clear_interrupt_id = stk_top.id;
                    stk_pop            = 1'b1;
                end else begin
                    reti_err = 1'b1;
                end
            end
        end
    end

    // One frame per priority level means legal traffic never overflows or underflows
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(stk_push && stk_full));
            assert (!(stk_pop && stk_empty));
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - scoreboard bench for interrupt_sequencer
module tb_interrupt_sequencer;

    localparam int          DEPTH = 16;
    localparam logic [15:0] VB    = 16'hFFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_enable;
    logic        insn_boundary;
    logic [15:0] current_pc;
    logic        reti;
    logic        handle_interrupt;
    logic        cpu_interrupt;
    logic [3:0]  cpu_interrupt_id;
    logic        clear_interrupt;
    logic [3:0]  clear_interrupt_id;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic [15:0] vec_data = 16'h0;
    logic        stall;
    logic        pc_load;
    logic [15:0] pc_value;
    logic [4:0]  nest_depth;
    logic        reti_err;

    always #5 clk = ~clk;

    interrupt_sequencer #(
        .DEPTH    (DEPTH),
        .PC_W     (16),
        .VEC_BASE (VB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .int_enable         (int_enable),
        .insn_boundary      (insn_boundary),
        .current_pc         (current_pc),
        .reti               (reti),
        .handle_interrupt   (handle_interrupt),
        .cpu_interrupt      (cpu_interrupt),
        .cpu_interrupt_id   (cpu_interrupt_id),
        .clear_interrupt    (clear_interrupt),
        .clear_interrupt_id (clear_interrupt_id),
        .vec_rd             (vec_rd),
        .vec_addr           (vec_addr),
        .vec_data           (vec_data),
        .stall              (stall),
        .pc_load            (pc_load),
        .pc_value           (pc_value),
        .nest_depth         (nest_depth),
        .reti_err           (reti_err)
    );

    typedef enum int {EV_VEC, EV_LOAD, EV_RET, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] val;
        logic [3:0]  id;
        int          cyc;
    } ev_t;
    typedef struct {
        logic [15:0] pc;
        logic [3:0]  id;
    } frame_t;

    ev_t         evq[$];
    frame_t      stk[$];
    logic [15:0] vec_table [16];

    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  mon_en   = 1'b0;
    bit  exp_handle = 1'b0;
    bit  exp_stall  = 1'b0;
    int  exp_depth  = 0;

    bit          m_ack   = 1'b0;
    bit          m_armed = 1'b0;
    logic [3:0]  m_id    = 4'h0;
    int          m_busy  = 0;
    logic [15:0] m_save_pc = 16'h0;
    bit          ctrl_req = 1'b0;
    logic [3:0]  ctrl_id  = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [15:0] v, input logic [3:0] id);
        evq.push_back('{k, v, id, cyc});
    endtask

    task automatic take(input ev_kind_t k, input logic [15:0] v, input logic [3:0] id);
        ev_t e;
        if (evq.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_event cyc=%0d actual=kind%0d/%0h required=none", cyc, k, v);
            return;
        end
        e = evq.pop_front();
        chk("event_kind", k, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("event_value", v, e.val);
        if (k == EV_RET) chk("clear_id", id, e.id);
    endtask

    // Drive one cycle of CPU/controller stimulus and predict the outcome from the rules
    task automatic step(input bit rst_i, input bit en, input bit bnd, input logic [15:0] pc, input bit rt);
        bit     reti_now;
        bit     ci;
        frame_t f;
        ci = !rst_i && m_ack && ctrl_req;
        reset = rst_i;
        int_enable = en;
        insn_boundary = bnd;
        current_pc = pc;
        reti = rt;
        cpu_interrupt = ci;
        cpu_interrupt_id = ci ? ctrl_id : 4'($urandom);
        exp_handle = 1'b0;
        exp_stall = 1'b0;
        exp_depth = rst_i ? 0 : stk.size();
        if (rst_i) begin
            stk.delete();
            m_ack = 1'b0;
            m_armed = 1'b0;
            m_busy = 0;
        end else if (m_busy == 2) begin
            exp_stall = 1'b1;
            expect_ev(EV_VEC, VB + 16'(m_id), 4'h0);
            m_busy = 1;
        end else if (m_busy == 1) begin
            exp_stall = 1'b1;
            expect_ev(EV_LOAD, vec_table[m_id], 4'h0);
            stk.push_back('{m_save_pc, m_id});
            m_busy = 0;
        end else begin
            reti_now = rt && bnd;
            if (!m_ack && !m_armed) exp_handle = en && (stk.size() < DEPTH) && !reti_now;
            if (reti_now) begin
                if (stk.size() > 0) begin
                    f = stk.pop_back();
                    expect_ev(EV_RET, f.pc, f.id);
                end else begin
                    expect_ev(EV_ERR, 16'h0, 4'h0);
                end
            end
            if (m_ack) begin
                m_ack = 1'b0;
                if (ci) begin
                    m_armed = 1'b1;
                    m_id = ctrl_id;
                    ctrl_req = 1'b0;
                end
            end else if (m_armed) begin
                if (bnd && !rt) begin
                    m_save_pc = pc;
                    m_armed = 1'b0;
                    m_busy = 2;
                end
            end else if (exp_handle) begin
                m_ack = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic arm(input logic [3:0] id);
        ctrl_req = 1'b1;
        ctrl_id = id;
        for (int i = 0; i < 10 && !m_armed; i++) step(1'b0, 1'b1, 1'b0, 16'($urandom), 1'b0);
    endtask

    task automatic vector_at(input bit en, input logic [15:0] pc);
        step(1'b0, en, 1'b1, pc, 1'b0);
        step(1'b0, en, 1'b0, 16'($urandom), 1'b0);
        step(1'b0, en, 1'b0, 16'($urandom), 1'b0);
    endtask

    // Vector-table memory: data is valid the cycle after the read strobe
    initial begin : vec_mem
        logic        p;
        logic [15:0] a;
        logic [15:0] off;
        forever begin
            @(negedge clk);
            p = vec_rd;
            a = vec_addr;
            @(posedge clk);
            #1;
            off = a - VB;
            vec_data = p ? vec_table[off[3:0]] : 16'($urandom);
        end
    end

    // Monitor: per-cycle checks plus scoreboard pops whenever the DUT presents an event
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_assert++;
                n_fail++;
                $display("FAIL missed_event cyc=%0d actual=none required=kind%0d/%0h", e.cyc, e.kind, e.val);
            end
            chk("handle_interrupt", handle_interrupt, exp_handle);
            chk("stall", stall, exp_stall);
            chk("nest_depth", nest_depth, exp_depth);
            chk("handle_with_clear", handle_interrupt & clear_interrupt, 1'b0);
            if (vec_rd) take(EV_VEC, vec_addr, 4'h0);
            if (pc_load && clear_interrupt) take(EV_RET, pc_value, clear_interrupt_id);
            else if (pc_load) take(EV_LOAD, pc_value, 4'h0);
            else if (clear_interrupt) take(EV_RET, 16'h0, clear_interrupt_id);
            if (reti_err) take(EV_ERR, 16'h0, 4'h0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        bit en, bnd, rt;
        for (int i = 0; i < 16; i++) vec_table[i] = 16'($urandom);
        vec_table[3] = 16'h0200;
        vec_table[7] = 16'h0300;
        vec_table[5] = 16'h0400;

        reset = 1'b1; int_enable = 1'b1; insn_boundary = 1'b1; reti = 1'b1;
        current_pc = 16'h1234; cpu_interrupt = 1'b0; cpu_interrupt_id = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_handle", handle_interrupt, 1'b0);
        chk("rst_clear", clear_interrupt, 1'b0);
        chk("rst_clear_id", clear_interrupt_id, 4'h0);
        chk("rst_vec_rd", vec_rd, 1'b0);
        chk("rst_vec_addr", vec_addr, 16'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_pc_load", pc_load, 1'b0);
        chk("rst_pc_value", pc_value, 16'h0);
        chk("rst_depth", nest_depth, 5'd0);
        chk("rst_reti_err", reti_err, 1'b0);
        mon_en = 1'b1;

        // Single interrupt, then nesting and unwinding, then RETI with nothing to return to
        arm(4'd3);
        vector_at(1'b1, 16'h0040);
        arm(4'd7);
        vector_at(1'b1, 16'h0205);
        repeat (3) step(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1);

        // RETI at the same boundary that would vector an armed interrupt
        arm(4'd3);
        vector_at(1'b1, 16'h0100);
        arm(4'd5);
        step(1'b0, 1'b1, 1'b1, 16'h0111, 1'b1);
        vector_at(1'b1, 16'h0111);
        step(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1);

        // Interrupts disabled, then disabled after acceptance
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'($urandom), 16'($urandom), 1'b0);
        arm(4'd2);
        step(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        vector_at(1'b0, 16'h0777);
        step(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b1);

        // Reset while reading the vector table, with a frame already on the stack
        arm(4'd1);
        vector_at(1'b1, 16'h0500);
        arm(4'd9);
        step(1'b0, 1'b1, 1'b1, 16'h0abc, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);

        // Fill every level, confirm no further handles, then unwind
        for (int i = 0; i < DEPTH; i++) begin
            arm(4'(i));
            vector_at(1'b1, 16'h1000 + 16'(i));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!ctrl_req && $urandom_range(0, 3) == 0) begin
                ctrl_req = 1'b1;
                ctrl_id = 4'($urandom);
            end
            en  = ($urandom_range(0, 9) != 0);
            bnd = 1'($urandom);
            rt  = (m_busy == 0) && ($urandom_range(0, 3) == 0);
            step(1'b0, en, bnd, 16'($urandom), rt);
        end
        ctrl_req = 1'b0;
        repeat (4) step(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        @(negedge clk);
        #1;
        chk("leftover_events", evq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
